spell_sequencer: RTL

Control sequencer that drives the `spell_execute` stage of the spell stack CPU. It fetches each opcode from code memory and, for `?`/`r`, performs the operand load. It presents pc, sp and the top two stack entries to the execute stage, then commits its results: stack writes, pc/sp update, memory write, delay and sleep. It owns the 32×8 stack register file and the single external memory handshake port.

---
 rtl/spell_sequencer_if.sv | 31 +++
 rtl/spell_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spell_sequencer_if.sv
// Memory handshake port shared by the spell sequencer and its memory.
// One outstanding request; mem_req is held until mem_ack.
interface spell_sequencer_if;
  logic [7:0] mem_addr;
  logic [1:0] mem_type;
  logic       mem_write;
  logic [7:0] mem_wdata;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_type,
    output mem_write,
    output mem_wdata,
    output mem_req,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_type,
    input  mem_write,
    input  mem_wdata,
    input  mem_req,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/spell_sequencer.sv
// Spell stack CPU control sequencer: fetch, operand load, commit,
// store, delay and sleep around the spell_execute stage.
module spell_sequencer #(
  parameter int DELAY_TICKS = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  spell_sequencer_if.master mem,
  output logic [7:0] exec_opcode,
  output logic [7:0] exec_pc,
  output logic [4:0] exec_sp,
  output logic [7:0] exec_stack_top,
  output logic [7:0] exec_stack_belowtop,
  output logic [7:0] exec_memory_input,
  input  logic [7:0] next_pc,
  input  logic [4:0] next_sp,
  input  logic [1:0] stack_write_count,
  input  logic [7:0] set_stack_top,
  input  logic [7:0] set_stack_belowtop,
  input  logic [7:0] memory_write_data,
  input  logic [7:0] memory_write_addr,
  input  logic [1:0] memory_write_type,
  input  logic [7:0] delay_amount,
  input  logic       sleep,
  output logic [7:0] pc,
  output logic [4:0] sp,
  output logic       busy,
  output logic       sleeping
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_STORE = 3'd4;
  localparam logic [2:0] S_DELAY = 3'd5;
  localparam logic [2:0] S_SLEEP = 3'd6;

  localparam logic [7:0] OP_CODE = 8'h3F;
  localparam logic [7:0] OP_DATA = 8'h72;
  localparam logic [1:0] T_DATA  = 2'd1;
  localparam logic [1:0] T_CODE  = 2'd2;

  logic [2:0]  state;
  logic [7:0]  pc_q;
  logic [4:0]  sp_q;
  logic [7:0]  op_q;
  logic [7:0]  top_q;
  logic [7:0]  below_q;
  logic [7:0]  min_q;
  logic [1:0]  ltype_q;
  logic [1:0]  wtype_q;
  logic [7:0]  waddr_q;
  logic [7:0]  wdata_q;
  logic        slp_q;
  logic [7:0]  dly_q;
  logic [23:0] cnt_q;

  logic [7:0] stack [32];

  logic [4:0] rd1;
  logic [4:0] rd2;
  logic [4:0] wr1;
  logic [4:0] wr2;

  assign rd1 = sp_q - 5'd1;
  assign rd2 = sp_q - 5'd2;
  assign wr1 = next_sp - 5'd1;
  assign wr2 = next_sp - 5'd2;

  function automatic logic [23:0] ticks(input logic [7:0] n);
    logic [31:0] p;
    p = 32'(n) * 32'(DELAY_TICKS);
    return p[23:0];
  endfunction

  // Common exit once an instruction's memory side effects are done.
  function automatic logic [2:0] exit_state(
    input logic       slp,
    input logic [7:0] dly,
    input logic       go
  );
    if (slp)
      return S_SLEEP;
    else if (dly != 8'd0)
      return S_DELAY;
    else if (go)
      return S_FETCH;
    return S_IDLE;
  endfunction

  always_ff @(posedge clock) begin
    if (state == S_EXEC) begin
      if (stack_write_count != 2'd0)
        stack[wr1] <= set_stack_top;
      if (stack_write_count[1])
        stack[wr2] <= set_stack_belowtop;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      pc_q    <= 8'd0;
      sp_q    <= 5'd0;
      op_q    <= 8'd0;
      top_q   <= 8'd0;
      below_q <= 8'd0;
      min_q   <= 8'd0;
      ltype_q <= 2'd0;
      wtype_q <= 2'd0;
      waddr_q <= 8'd0;
      wdata_q <= 8'd0;
      slp_q   <= 1'b0;
      dly_q   <= 8'd0;
      cnt_q   <= 24'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run)
            state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem.mem_ack) begin
            op_q    <= mem.mem_rdata;
            top_q   <= stack[rd1];
            below_q <= stack[rd2];
            if (mem.mem_rdata == OP_CODE) begin
              ltype_q <= T_CODE;
              state   <= S_LOAD;
            end else if (mem.mem_rdata == OP_DATA) begin
              ltype_q <= T_DATA;
              state   <= S_LOAD;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_LOAD: begin
          if (mem.mem_ack) begin
            min_q <= mem.mem_rdata;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc_q    <= next_pc;
          sp_q    <= next_sp;
          wtype_q <= memory_write_type;
          waddr_q <= memory_write_addr;
          wdata_q <= memory_write_data;
          slp_q   <= sleep;
          dly_q   <= delay_amount;
          if (memory_write_type != 2'd0) begin
            state <= S_STORE;
          end else begin
            state <= exit_state(sleep, delay_amount, run);
            cnt_q <= ticks(delay_amount);
          end
        end
        S_STORE: begin
          if (mem.mem_ack) begin
            state <= exit_state(slp_q, dly_q, run);
            cnt_q <= ticks(dly_q);
          end
        end
        S_DELAY: begin
          if (cnt_q <= 24'd1) begin
            cnt_q <= 24'd0;
            state <= run ? S_FETCH : S_IDLE;
          end else begin
            cnt_q <= cnt_q - 24'd1;
          end
        end
        S_SLEEP: begin
          if (!run)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Request fields are decoded from state so reset drops mem_req at once.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.mem_addr  = 8'd0;
    mem.mem_type  = 2'd0;
    mem.mem_wdata = 8'd0;
    unique case (1'b1)
      state == S_FETCH: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = pc_q;
        mem.mem_type = T_CODE;
      end
      state == S_LOAD: begin
        mem.mem_req  = 1'b1;
        mem.mem_addr = top_q;
        mem.mem_type = ltype_q;
      end
      state == S_STORE: begin
        mem.mem_req   = 1'b1;
        mem.mem_write = 1'b1;
        mem.mem_addr  = waddr_q;
        mem.mem_type  = wtype_q;
        mem.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  assign exec_opcode         = op_q;
  assign exec_pc             = pc_q;
  assign exec_sp             = sp_q;
  assign exec_stack_top      = top_q;
  assign exec_stack_belowtop = below_q;
  assign exec_memory_input   = min_q;
  assign pc                  = pc_q;
  assign sp                  = sp_q;
  assign busy                = state != S_IDLE;
  assign sleeping            = state == S_SLEEP;

endmodule
